// File: rtl/proc_feeder.sv
// proc_feeder: instruction-stream sequencer feeding a 9-bit bus processor.
// Holds a loadable program memory, issues one word per Run/Done handshake,
// supplies the mvi immediate, stops on HALT_WORD and watchdogs a stuck processor.
module proc_feeder #(
    parameter int unsigned N         = 9,
    parameter int unsigned AW        = 5,
    parameter logic [N-1:0] HALT_WORD = 9'b111111111,
    parameter int unsigned TIMEOUT   = 16
) (
    input  logic          i_clock,
    input  logic          i_reset,
    input  logic          i_load_en,
    input  logic [AW-1:0] i_load_addr,
    input  logic [N-1:0]  i_load_data,
    input  logic          i_start,
    input  logic          i_done,
    output logic [N-1:0]  o_din,
    output logic          o_run,
    output logic [AW-1:0] o_pc,
    output logic          o_busy,
    output logic          o_halted,
    output logic          o_fault,
    output logic [7:0]    o_icount
);

    localparam int unsigned DEPTH = 2 ** AW;
    localparam int unsigned WDW   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [2:0]  OP_MVI = 3'b001;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_IMM,
        S_WAIT,
        S_HALTED,
        S_FAULT
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [N-1:0]     r_mem [DEPTH];
    logic [AW-1:0]    r_pc;
    logic [AW-1:0]    w_pc_nxt;
    logic [N-1:0]     r_din;
    logic [N-1:0]     w_din_nxt;
    logic             r_run;
    logic             r_busy;
    logic             r_halted;
    logic             r_fault;
    logic [7:0]       r_icount;
    logic [7:0]       w_icount_nxt;
    logic [WDW-1:0]   r_wd;
    logic [WDW-1:0]   w_wd_nxt;
    logic             w_disp;
    logic [AW-1:0]    w_disp_pc;
    logic [N-1:0]     w_disp_word;
    logic [N-1:0]     w_rd;
    logic [N-1:0]     w_rd0;

    // Combinational reads: word at PC, and word at 0 for restart dispatch
    assign w_rd  = r_mem[r_pc];
    assign w_rd0 = r_mem[0];

    // Program memory write; blocked during reset and while executing
    always_ff @(posedge i_clock) begin
        if (!i_reset && i_load_en && !r_busy) begin
            r_mem[i_load_addr] <= i_load_data;
        end
    end

    // Next-state, PC, DIN, instruction count and watchdog decode
    always_comb begin
        w_state_nxt  = r_state;
        w_pc_nxt     = r_pc;
        w_din_nxt    = '0;
        w_icount_nxt = r_icount;
        w_wd_nxt     = '0;
        w_disp       = 1'b0;
        w_disp_pc    = r_pc;
        w_disp_word  = w_rd;

        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_disp       = 1'b1;
                    w_icount_nxt = 8'd0;
                end
            end
            S_ISSUE: begin
                if (r_din[N-1 -: 3] == OP_MVI) begin
                    w_state_nxt = S_IMM;
                    w_din_nxt   = w_rd;
                    w_pc_nxt    = r_pc + AW'(1);
                end else begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_IMM: begin
                if (i_done) begin
                    w_icount_nxt = r_icount + 8'd1;
                    w_disp       = 1'b1;
                end else begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (i_done) begin
                    w_icount_nxt = r_icount + 8'd1;
                    w_disp       = 1'b1;
                end else if (r_wd == WDW'(TIMEOUT - 1)) begin
                    w_state_nxt = S_FAULT;
                end else begin
                    w_wd_nxt = r_wd + WDW'(1);
                end
            end
            S_HALTED, S_FAULT: begin
                if (i_start) begin
                    w_disp       = 1'b1;
                    w_disp_pc    = '0;
                    w_disp_word  = w_rd0;
                    w_icount_nxt = 8'd0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Shared dispatch: stop on HALT_WORD, otherwise issue and advance
        if (w_disp) begin
            if (w_disp_word == HALT_WORD) begin
                w_state_nxt = S_HALTED;
                w_pc_nxt    = w_disp_pc;
            end else begin
                w_state_nxt = S_ISSUE;
                w_din_nxt   = w_disp_word;
                w_pc_nxt    = w_disp_pc + AW'(1);
            end
        end
    end

    // State and registered output update with synchronous reset
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state  <= S_IDLE;
            r_pc     <= '0;
            r_din    <= '0;
            r_run    <= 1'b0;
            r_busy   <= 1'b0;
            r_halted <= 1'b0;
            r_fault  <= 1'b0;
            r_icount <= 8'd0;
            r_wd     <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_pc     <= w_pc_nxt;
            r_din    <= w_din_nxt;
            r_run    <= (w_state_nxt == S_ISSUE);
            r_busy   <= (w_state_nxt == S_ISSUE) || (w_state_nxt == S_IMM) ||
                        (w_state_nxt == S_WAIT);
            r_halted <= (w_state_nxt == S_HALTED);
            r_fault  <= (w_state_nxt == S_FAULT);
            r_icount <= w_icount_nxt;
            r_wd     <= w_wd_nxt;
        end
    end

    assign o_din    = r_din;
    assign o_run    = r_run;
    assign o_pc     = r_pc;
    assign o_busy   = r_busy;
    assign o_halted = r_halted;
    assign o_fault  = r_fault;
    assign o_icount = r_icount;

endmodule

// File: tb/tb_proc_feeder.sv
// tb_proc_feeder: directed bench for proc_feeder with hand-computed expectations.
module tb_proc_feeder;

    localparam logic [8:0] MV   = 9'o050;
    localparam logic [8:0] MV2  = 9'o052;
    localparam logic [8:0] MVI  = 9'o150;
    localparam logic [8:0] HALT = 9'o777;

    logic       clk;
    logic       reset;
    logic       load_en;
    logic [4:0] load_addr;
    logic [8:0] load_data;
    logic       start;
    logic       done;
    logic [8:0] din;
    logic       run;
    logic [4:0] pc;
    logic       busy;
    logic       halted;
    logic       fault;
    logic [7:0] icount;

    int n_cmp = 0;
    int n_err = 0;

    proc_feeder #(.N(9), .AW(5), .HALT_WORD(9'b111111111), .TIMEOUT(16)) dut (
        .i_clock    (clk),
        .i_reset    (reset),
        .i_load_en  (load_en),
        .i_load_addr(load_addr),
        .i_load_data(load_data),
        .i_start    (start),
        .i_done     (done),
        .o_din      (din),
        .o_run      (run),
        .o_pc       (pc),
        .o_busy     (busy),
        .o_halted   (halted),
        .o_fault    (fault),
        .o_icount   (icount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [4:0] a, input logic [8:0] d);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        tick();
        load_en   = 1'b0;
    endtask

    initial begin
        reset = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0;
        start = 1'b0; done = 1'b0;

        // Reset dominates Start
        tick();
        start = 1'b1;
        tick();
        chk("rst_run", run, 0);
        chk("rst_din", din, 0);
        chk("rst_pc", pc, 0);
        chk("rst_icount", icount, 0);
        chk("rst_busy", busy, 0);
        chk("rst_halted", halted, 0);
        chk("rst_fault", fault, 0);
        start = 1'b0;
        reset = 1'b0;
        tick();

        // Single mv then HALT
        load(5'd0, MV);
        load(5'd1, HALT);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t1_run", run, 1);
        chk("t1_din", din, MV);
        chk("t1_pc", pc, 1);
        chk("t1_busy", busy, 1);
        tick();
        chk("t1_wait_run", run, 0);
        chk("t1_wait_din", din, 0);
        done = 1'b1;
        tick();
        done = 1'b0;
        chk("t1_halted", halted, 1);
        chk("t1_icount", icount, 1);
        chk("t1_pc_end", pc, 1);
        chk("t1_busy_end", busy, 0);

        // mvi with immediate
        load(5'd0, MVI);
        load(5'd1, 9'd300);
        load(5'd2, HALT);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t2_run", run, 1);
        chk("t2_din_op", din, MVI);
        chk("t2_pc1", pc, 1);
        tick();
        chk("t2_imm_run", run, 0);
        chk("t2_imm_din", din, 9'd300);
        chk("t2_pc2", pc, 2);
        tick();
        chk("t2_wait_din", din, 0);
        done = 1'b1;
        tick();
        done = 1'b0;
        chk("t2_halted", halted, 1);
        chk("t2_icount", icount, 1);
        chk("t2_pc_end", pc, 2);

        // Back-to-back issue
        load(5'd0, MV);
        load(5'd1, MV2);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t3_first_din", din, MV);
        tick();
        chk("t3_wait_run", run, 0);
        done = 1'b1;
        tick();
        done = 1'b0;
        chk("t3_second_run", run, 1);
        chk("t3_second_din", din, MV2);
        chk("t3_icount_mid", icount, 1);
        chk("t3_pc_mid", pc, 2);
        tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        chk("t3_halted", halted, 1);
        chk("t3_icount", icount, 2);

        // Watchdog: Done during ISSUE ignored, FAULT 16 cycles after entering WAIT
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t4_issue_run", run, 1);
        chk("t4_icount_clr", icount, 0);
        done = 1'b1;
        tick();
        done = 1'b0;
        chk("t4_done_in_issue_ignored", icount, 0);
        chk("t4_wait_busy", busy, 1);
        for (int i = 0; i < 15; i++) tick();
        chk("t4_no_fault_15", fault, 0);
        chk("t4_busy_15", busy, 1);
        tick();
        chk("t4_fault_16", fault, 1);
        chk("t4_busy_16", busy, 0);
        chk("t4_halted_excl", halted, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t4_restart_run", run, 1);
        chk("t4_restart_pc", pc, 1);
        chk("t4_restart_din", din, MV);
        chk("t4_restart_fault", fault, 0);
        tick();

        // Load during Busy is ignored; reset during WAIT
        load(5'd0, 9'o077);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t6_rst_run", run, 0);
        chk("t6_rst_din", din, 0);
        chk("t6_rst_pc", pc, 0);
        chk("t6_rst_icount", icount, 0);
        chk("t6_rst_busy", busy, 0);
        // Same-cycle write to mem[0] with Start: old word issued
        start = 1'b1; load_en = 1'b1; load_addr = 5'd0; load_data = 9'o066;
        tick();
        start = 1'b0; load_en = 1'b0;
        chk("t6_old_word", din, MV);
        reset = 1'b1;
        tick();
        reset = 1'b0;

        // PC wrap inside an mvi pair
        for (int i = 0; i < 32; i++) load(5'(i), (i == 31) ? MVI : MV);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 31; i++) begin
            tick();
            done = 1'b1;
            tick();
            done = 1'b0;
        end
        chk("t5_mvi_run", run, 1);
        chk("t5_mvi_din", din, MVI);
        chk("t5_pc_wrap", pc, 0);
        chk("t5_icount31", icount, 31);
        tick();
        chk("t5_imm_from_0", din, MV);
        chk("t5_pc_after", pc, 1);
        done = 1'b1;
        tick();
        done = 1'b0;
        chk("t5_icount32", icount, 32);
        chk("t5_next_pc", pc, 2);
        chk("t5_next_run", run, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
